// File: rtl/road_scroll_ctrl_if.sv
// Game-logic <-> road scroll scheduler signal bundle.
// master = game logic side, slave = road_scroll_ctrl.
interface road_scroll_ctrl_if;
  logic [1:0] level;
  logic       run;
  logic       crash;
  logic       frame_start;
  logic [9:0] scroll_offset;
  logic       step_pulse;
  logic [1:0] level_active;
  logic [1:0] state;

  modport master (
    output level, run, crash, frame_start,
    input  scroll_offset, step_pulse, level_active, state
  );

  modport slave (
    input  level, run, crash, frame_start,
    output scroll_offset, step_pulse, level_active, state
  );
endinterface

// File: rtl/road_scroll_ctrl.sv
// Road scroll scheduler: prescaled timebase, level-dependent step divider, RUN/BRAKE/HALT FSM.
// All outputs registered (1 clk after the deciding input); no backpressure, scroll_offset published only on frame_start.
module road_scroll_ctrl #(
  parameter int CLK_HZ      = 100000000,
  parameter int BASE_HZ     = 500,
  parameter int STEP        = 8,
  parameter int PERIOD      = 96,
  parameter int BRAKE_DIV   = 8,
  parameter int BRAKE_STEPS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  road_scroll_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int PRESC_N = CLK_HZ / BASE_HZ;
  localparam int PW      = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam int DIV_MAX = (BRAKE_DIV > 6) ? BRAKE_DIV : 6;
  localparam int DW      = $clog2(DIV_MAX + 1);
  localparam int BW      = (BRAKE_STEPS > 1) ? $clog2(BRAKE_STEPS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_N - 1);
  localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_STEPS - 1);
  localparam logic [10:0]   STEP_W     = 11'(STEP);
  localparam logic [10:0]   PERIOD_W   = 11'(PERIOD);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] brake_cnt_q, brake_cnt_d;
  logic [9:0]    off_q, off_d;
  logic [9:0]    scroll_offset_q, scroll_offset_d;
  logic          step_pulse_q, step_pulse_d;
  logic [1:0]    level_active_q, level_active_d;

  logic          moving;
  logic          base_tick;
  logic [DW-1:0] div_lim;
  logic          div_done;
  logic          step;
  logic [10:0]   off_sum;

  always_comb begin
    state_d         = state_q;
    presc_d         = presc_q;
    div_d           = div_q;
    brake_cnt_d     = brake_cnt_q;
    off_d           = off_q;
    scroll_offset_d = scroll_offset_q;
    step_pulse_d    = 1'b0;
    level_active_d  = level_active_q;
    step            = 1'b0;
    off_sum         = {1'b0, off_q} + STEP_W;

    moving    = (state_q == RUN) || (state_q == BRAKE);
    base_tick = moving && (presc_q == PRESC_LAST);

    // Divider limit is DIV-1; >= keeps a level drop from stranding a larger count.
    if (state_q == BRAKE) begin
      div_lim = DW'(BRAKE_DIV - 1);
    end else begin
      case (level_active_q)
        2'd0:    div_lim = DW'(5);
        2'd1:    div_lim = DW'(3);
        2'd2:    div_lim = DW'(1);
        default: div_lim = DW'(0);
      endcase
    end
    div_done = (div_q >= div_lim);

    if (moving) begin
      presc_d = base_tick ? '0 : presc_q + PW'(1);
    end
    if (base_tick) begin
      div_d = div_done ? '0 : div_q + DW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.run && !bus.crash) state_d = RUN;
      end
      RUN: begin
        if (bus.crash) begin
          state_d = HALT;
        end else if (!bus.run) begin
          state_d     = BRAKE;
          brake_cnt_d = '0;
          div_d       = '0;
        end else begin
          step = base_tick && div_done;
        end
      end
      BRAKE: begin
        if (bus.crash) begin
          state_d = HALT;
        end else if (bus.run) begin
          state_d = RUN;
          div_d   = '0;
        end else if (base_tick && div_done) begin
          step = 1'b1;
          if (brake_cnt_q == BRAKE_LAST) begin
            state_d = IDLE;
          end else begin
            brake_cnt_d = brake_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        if (!bus.crash && !bus.run) state_d = IDLE;
      end
    endcase

    // Stopped states keep the timebase parked so a restart sees a full DIV period.
    if ((state_d == IDLE) || (state_d == HALT)) begin
      presc_d = '0;
      div_d   = '0;
    end

    if (step) begin
      step_pulse_d = 1'b1;
      off_d        = (off_sum >= PERIOD_W) ? 10'(off_sum - PERIOD_W) : off_sum[9:0];
    end

    // off_q is the pre-step value, so a coincident step is not published until next frame.
    if (bus.frame_start) begin
      scroll_offset_d = off_q;
      level_active_d  = bus.level;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      presc_q         <= '0;
      div_q           <= '0;
      brake_cnt_q     <= '0;
      off_q           <= '0;
      scroll_offset_q <= '0;
      step_pulse_q    <= 1'b0;
      level_active_q  <= 2'd0;
    end else begin
      state_q         <= state_d;
      presc_q         <= presc_d;
      div_q           <= div_d;
      brake_cnt_q     <= brake_cnt_d;
      off_q           <= off_d;
      scroll_offset_q <= scroll_offset_d;
      step_pulse_q    <= step_pulse_d;
      level_active_q  <= level_active_d;
    end
  end

  assign bus.scroll_offset = scroll_offset_q;
  assign bus.step_pulse    = step_pulse_q;
  assign bus.level_active  = level_active_q;
  assign bus.state         = state_q;

endmodule
